// File: rtl/mem_port_arbiter.sv
// Arbitrates one line-wide memory port between the I-side (read-only) and
// D-side (read/write) miss paths: round-robin, one transaction in flight.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t            state;
   logic              last_d;
   logic [ADDR_W-1:0] cap_addr;
   logic [LINE_W-1:0] cap_wdata;
   logic              want_i;
   logic              want_d;
   logic              grant_d;

   assign want_i  = i_read;
   assign want_d  = d_read | d_write;
   // On a tie the side that was not served last wins; last_d resets to I so D wins first.
   assign grant_d = want_d & (~want_i | ~last_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_d     <= 1'b0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state      <= SERVE_D;
                  last_d     <= 1'b1;
                  cap_addr   <= d_address;
                  cap_wdata  <= d_wdata;
                  pmem_write <= d_write;
                  pmem_read  <= ~d_write;
               end else if (want_i) begin
                  state      <= SERVE_I;
                  last_d     <= 1'b0;
                  cap_addr   <= i_address;
                  cap_wdata  <= '0;
                  pmem_write <= 1'b0;
                  pmem_read  <= 1'b1;
               end
            end
            SERVE_I, SERVE_D: begin
               if (pmem_resp) begin
                  state      <= IDLE;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
            end
         endcase
      end
   end

   assign pmem_address = cap_addr;
   assign pmem_wdata   = cap_wdata;
   assign i_resp       = (state == SERVE_I) & pmem_resp;
   assign d_resp       = (state == SERVE_D) & pmem_resp;
   assign i_rdata      = pmem_rdata;
   assign d_rdata      = pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responses are driven by hand
// at negedges and every output is compared with hand-computed values.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write, pmem_resp;
   logic [AW-1:0] i_address, d_address;
   logic [LW-1:0] d_wdata, pmem_rdata;
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic          i_resp, d_resp, pmem_read, pmem_write;
   logic [AW-1:0] pmem_address;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
      @(negedge clk); @(negedge clk);
      check("rst_pmem_read",  LW'(pmem_read),  LW'(0));
      check("rst_pmem_write", LW'(pmem_write), LW'(0));
      check("rst_addr",       LW'(pmem_address), LW'(0));
      check("rst_i_resp",     LW'(i_resp),     LW'(0));
      check("rst_d_resp",     LW'(d_resp),     LW'(0));
      rst = 1'b0;

      // 1: lone I read, memory answers on the third SERVE cycle
      i_read = 1'b1; i_address = 32'h0000_1000;
      tick;
      check("t1_pmem_read",  LW'(pmem_read),    LW'(1));
      check("t1_pmem_write", LW'(pmem_write),   LW'(0));
      check("t1_addr",       LW'(pmem_address), LW'(32'h1000));
      tick;
      check("t1_no_resp_early", LW'(i_resp), LW'(0));
      tick;
      pmem_rdata = {32{8'hA5}}; pmem_resp = 1'b1;
      #1;
      check("t1_i_resp",  LW'(i_resp), LW'(1));
      check("t1_i_rdata", i_rdata,     {32{8'hA5}});
      check("t1_d_resp",  LW'(d_resp), LW'(0));
      tick;
      pmem_resp = 1'b0; i_read = 1'b0;
      check("t1_idle_read", LW'(pmem_read), LW'(0));

      // 2: lone D write
      d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = {8{32'h1234_5678}};
      tick;
      check("t2_pmem_write", LW'(pmem_write),   LW'(1));
      check("t2_pmem_read",  LW'(pmem_read),    LW'(0));
      check("t2_addr",       LW'(pmem_address), LW'(32'h2040));
      check("t2_wdata",      pmem_wdata,        {8{32'h1234_5678}});
      pmem_resp = 1'b1;
      #1;
      check("t2_d_resp", LW'(d_resp), LW'(1));
      check("t2_i_resp", LW'(i_resp), LW'(0));
      tick;
      pmem_resp = 1'b0; d_write = 1'b0;
      #1;
      check("t2_d_resp_pulse", LW'(d_resp),     LW'(0));
      check("t2_idle_write",   LW'(pmem_write), LW'(0));

      // 3: contention straight after reset, both sides held: D,I,D,I
      rst = 1'b1;
      tick;
      rst = 1'b0;
      i_read = 1'b1; i_address = 32'h0000_5000;
      d_read = 1'b1; d_address = 32'h0000_6000;
      for (int k = 0; k < 4; k++) begin
         tick;
         check("t3_grant_addr", LW'(pmem_address), (k % 2 == 0) ? LW'(32'h6000) : LW'(32'h5000));
         check("t3_pmem_read",  LW'(pmem_read), LW'(1));
         pmem_resp = 1'b1;
         #1;
         check("t3_d_resp", LW'(d_resp), (k % 2 == 0) ? LW'(1) : LW'(0));
         check("t3_i_resp", LW'(i_resp), (k % 2 == 0) ? LW'(0) : LW'(1));
         tick;
         pmem_resp = 1'b0;
         check("t3_bubble", LW'(pmem_read), LW'(0));
      end
      i_read = 1'b0; d_read = 1'b0;
      tick;

      // 4: address change mid-transaction is ignored
      d_read = 1'b1; d_address = 32'h0000_3000;
      tick;
      check("t4_addr_first", LW'(pmem_address), LW'(32'h3000));
      d_address = 32'h0000_4000;
      tick;
      check("t4_addr_held", LW'(pmem_address), LW'(32'h3000));
      pmem_resp = 1'b1;
      #1;
      check("t4_addr_at_resp", LW'(pmem_address), LW'(32'h3000));
      check("t4_d_resp",       LW'(d_resp),       LW'(1));
      tick;
      pmem_resp = 1'b0; d_read = 1'b0;

      // 5: stray pmem_resp in IDLE
      pmem_resp = 1'b1;
      #1;
      check("t5_i_resp", LW'(i_resp), LW'(0));
      check("t5_d_resp", LW'(d_resp), LW'(0));
      tick;
      pmem_resp = 1'b0;
      check("t5_idle_read",  LW'(pmem_read),  LW'(0));
      check("t5_idle_write", LW'(pmem_write), LW'(0));

      // 6: async reset mid SERVE_D with an I read pending
      d_write = 1'b1; d_address = 32'h0000_7000;
      tick;
      check("t6_write_on", LW'(pmem_write), LW'(1));
      i_read = 1'b1; i_address = 32'h0000_8000;
      #2 rst = 1'b1;
      #1;
      check("t6_async_write_off", LW'(pmem_write), LW'(0));
      check("t6_async_d_resp",    LW'(d_resp),     LW'(0));
      d_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t6_idle_after_rst", LW'(pmem_read), LW'(0));
      tick;
      check("t6_i_granted", LW'(pmem_read),    LW'(1));
      check("t6_i_addr",    LW'(pmem_address), LW'(32'h8000));
      pmem_resp = 1'b1;
      #1;
      check("t6_i_resp", LW'(i_resp), LW'(1));
      tick;
      pmem_resp = 1'b0; i_read = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
